ifu_fetch_queue: RTL and testbench

Parametrised fetch front-end sitting between the PC and the I-cache controller's CPU-side port. It generates sequential fetch addresses and issues one cache read at a time. Each 64-bit response is split into 32-bit instructions and buffered, with their PCs, in a DEPTH-entry queue that feeds decode through a valid/ready handshake. Redirect (branch, trap) flushes the queue and discards any fetch already in flight.

---
 rtl/ifu_pkg.sv | 17 +
 rtl/ifu_fq_fifo.sv | 82 ++++++++
 rtl/ifu_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifu_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_REQ  = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_t;

    // First fetch address after reset
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Instruction width; one cache line carries two instructions
    localparam int unsigned IFU_INST_W = 32;

endpackage

// File: rtl/ifu_fq_fifo.sv
// Circular {pc, inst} queue feeding decode.
// IFU_FQ_PAIR_EN adds a second push port so a full line can be queued in one cycle.
module ifu_fq_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = IFU_INST_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push1,
    input  logic [ADDR_W-1:0]        i_push1_pc,
    input  logic [INST_W-1:0]        i_push1_inst,
`ifdef IFU_FQ_PAIR_EN
    input  logic                     i_push2,
    input  logic [ADDR_W-1:0]        i_push2_pc,
    input  logic [INST_W-1:0]        i_push2_inst,
`endif
    input  logic                     i_pop,
    output logic [ADDR_W-1:0]        o_head_pc,
    output logic [INST_W-1:0]        o_head_inst,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_push_n;
    logic [CW-1:0]     w_pop_n;

    // Number of entries written and removed this cycle
    always_comb begin
        w_push_n = CW'(i_push1);
`ifdef IFU_FQ_PAIR_EN
        w_push_n = w_push_n + CW'(i_push2);
`endif
        w_pop_n  = CW'(i_pop);
    end

    // Storage, pointers and occupancy; flush empties the queue but leaves slot contents stale
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem_pc[k]   <= '0;
                r_mem_inst[k] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push1) begin
                r_mem_pc[r_wr]   <= i_push1_pc;
                r_mem_inst[r_wr] <= i_push1_inst;
            end
`ifdef IFU_FQ_PAIR_EN
            if (i_push2) begin
                r_mem_pc[r_wr + PW'(1)]   <= i_push2_pc;
                r_mem_inst[r_wr + PW'(1)] <= i_push2_inst;
            end
`endif
            r_wr    <= r_wr + PW'(w_push_n);
            r_rd    <= r_rd + PW'(w_pop_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    assign o_head_pc   = r_mem_pc[r_rd];
    assign o_head_inst = r_mem_inst[r_rd];
    assign o_count     = r_count;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch front-end: sequential PC generation, one outstanding cache read,
// word select into the fetch queue, redirect flush with in-flight drop.
// Optional feature macro: IFU_FQ_PAIR_EN (push both words of a line in one cycle).
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       LINE_W   = 64,
    parameter int unsigned       INST_W   = IFU_INST_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_W-1:0]      inst,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic [$clog2(DEPTH):0] fq_count,
    output logic                   fq_busy,
    output logic [ADDR_W-1:0]      cache_addr,
    output logic                   cache_r_ready,
    input  logic                   cache_r_valid,
    input  logic [LINE_W-1:0]      cache_r_data
);

    localparam int unsigned       CW        = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(7);

    fq_state_t         r_state;
    fq_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_cache_addr;
    logic [ADDR_W-1:0] w_cache_addr_nxt;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [INST_W-1:0] w_sel_inst;
    logic              w_push1;
    logic              w_pop;
`ifdef IFU_FQ_PAIR_EN
    logic              w_push2;
    logic              w_pair_ok;
`endif

    assign w_redirect_pc = redirect_pc & WORD_MASK;
    assign w_sel_inst    = r_fetch_pc[2] ? cache_r_data[INST_W +: INST_W]
                                         : cache_r_data[0 +: INST_W];
    assign w_pop         = inst_ready & inst_valid & ~redirect_valid;
`ifdef IFU_FQ_PAIR_EN
    // Free-slot test uses the registered count, ignoring a same-cycle pop
    assign w_pair_ok     = ~r_fetch_pc[2] & (fq_count <= CW'(DEPTH - 2));
`endif

    // State, fetch PC and the address held stable for the cache
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FQ_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_cache_addr <= RESET_PC & LINE_MASK;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_cache_addr <= w_cache_addr_nxt;
        end
    end

    // Next state, fetch PC update and push control; redirect always wins
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_cache_addr_nxt = r_cache_addr;
        w_push1          = 1'b0;
`ifdef IFU_FQ_PAIR_EN
        w_push2          = 1'b0;
`endif
        case (r_state)
            FQ_IDLE: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                end else if (fq_count < CW'(DEPTH)) begin
                    w_state_nxt      = FQ_REQ;
                    w_cache_addr_nxt = r_fetch_pc & LINE_MASK;
                end
            end
            FQ_REQ: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = cache_r_valid ? FQ_IDLE : FQ_DROP;
                end else if (cache_r_valid) begin
                    w_push1     = 1'b1;
                    w_state_nxt = FQ_IDLE;
`ifdef IFU_FQ_PAIR_EN
                    if (w_pair_ok) begin
                        w_push2        = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(8);
                    end else begin
                        w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
                    end
`else
                    w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
`endif
                end
            end
            FQ_DROP: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                end
                if (cache_r_valid) begin
                    w_state_nxt = FQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = FQ_IDLE;
            end
        endcase
    end

    ifu_fq_fifo #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_flush      (redirect_valid),
        .i_push1      (w_push1),
        .i_push1_pc   (r_fetch_pc),
        .i_push1_inst (w_sel_inst),
`ifdef IFU_FQ_PAIR_EN
        .i_push2      (w_push2),
        .i_push2_pc   (r_fetch_pc + ADDR_W'(4)),
        .i_push2_inst (cache_r_data[INST_W +: INST_W]),
`endif
        .i_pop        (w_pop),
        .o_head_pc    (inst_pc),
        .o_head_inst  (inst),
        .o_count      (fq_count)
    );

    assign inst_valid    = (fq_count != '0);
    assign cache_r_ready = (r_state != FQ_IDLE);
    assign fq_busy       = (r_state != FQ_IDLE);
    assign cache_addr    = r_cache_addr;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: a behavioural cache answers requests,
// expected {pc, inst} entries are queued when a response is driven and
// compared against the queue head each cycle.
module tb_ifu_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  fq_count;
    logic        fq_busy;
    logic [31:0] cache_addr;
    logic        cache_r_ready;
    logic        cache_r_valid;
    logic [63:0] cache_r_data;

    ifu_fetch_queue #(
        .ADDR_W   (32),
        .LINE_W   (64),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fq_count       (fq_count),
        .fq_busy        (fq_busy),
        .cache_addr     (cache_addr),
        .cache_r_ready  (cache_r_ready),
        .cache_r_valid  (cache_r_valid),
        .cache_r_data   (cache_r_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // stimulus knobs
    int unsigned lat       = 0;
    bit          rdy_rand  = 0;
    bit          rdy_val   = 0;
    bit          want_redir = 0;
    int unsigned redir_mode = 0;  // 0 now, 1 on a response cycle, 2 in REQ without response
    logic [31:0] want_pc   = '0;
    bit          force_rdy = 0;

    // bench-side model state
    logic [31:0] model_pc     = 32'h8000_0000;
    bit          drop_pending = 0;
    int unsigned wait_cnt     = 0;
    int unsigned req_cnt      = 0;
    bit          last_ready   = 0;
    bit          p_ready = 0, p_valid = 0, p_redir = 0;
    int unsigned p_size  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_0004) return 32'h0000_0297;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock: sample and check at negedge, then drive inputs and update the model
    task automatic step();
        int unsigned sz;
        bit          v;
        bit          do_redir;
        bit          rdy;
        bit          exp_ready;
        int unsigned free;
        bit          pair;
        @(negedge clk);
        sz        = q.size();
        exp_ready = p_ready ? !p_valid : (!p_redir && p_size < DEPTH);
        chk("cache_r_ready", cache_r_ready, exp_ready);
        chk("fq_busy", fq_busy, exp_ready);
        chk("fq_count", fq_count, sz);
        chk("inst_valid", inst_valid, sz != 0);
        if (sz != 0) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst", inst, q[0].ins);
        end
        if (cache_r_ready && !last_ready) req_cnt++;
        last_ready = cache_r_ready;

        v = 0;
        if (cache_r_ready) begin
            if (wait_cnt == 0) v = 1;
            else wait_cnt--;
        end else begin
            wait_cnt = lat;
        end
        do_redir = want_redir &&
                   ((redir_mode == 0) ||
                    (redir_mode == 1 && v) ||
                    (redir_mode == 2 && cache_r_ready && !v && !drop_pending));
        if (do_redir) want_redir = 0;
        rdy = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_val;
        if (do_redir && force_rdy) rdy = 1;
        if (v && !drop_pending) chk("cache_addr", cache_addr, model_pc & ~32'd7);

        cache_r_valid  = v;
        cache_r_data   = {mem_word(cache_addr + 32'd4), mem_word(cache_addr)};
        redirect_valid = do_redir;
        redirect_pc    = want_pc;
        inst_ready     = rdy;

        p_ready = cache_r_ready;
        p_valid = v;
        p_redir = do_redir;
        p_size  = sz;

        if (do_redir) begin
            q.delete();
            model_pc     = want_pc & ~32'd3;
            drop_pending = cache_r_ready && !v;
        end else begin
            if (rdy && sz != 0) void'(q.pop_front());
            if (v) begin
                if (!drop_pending) begin
                    free = DEPTH - sz;
`ifdef IFU_FQ_PAIR_EN
                    pair = (model_pc[2] == 1'b0) && (free >= 2);
`else
                    pair = 0;
`endif
                    q.push_back('{pc: model_pc, ins: mem_word(model_pc)});
                    if (pair) begin
                        q.push_back('{pc: model_pc + 32'd4, ins: mem_word(model_pc + 32'd4)});
                        model_pc = model_pc + 32'd8;
                    end else begin
                        model_pc = model_pc + 32'd4;
                    end
                end
                drop_pending = 0;
            end
        end
    endtask

    task automatic fire_redirect(input int unsigned mode, input logic [31:0] pc);
        int unsigned n = 0;
        want_redir = 1;
        redir_mode = mode;
        want_pc    = pc;
        while (want_redir && n < 60) begin step(); n++; end
        chk("tmo_redirect", n < 60, 1);
        want_redir = 0;
    endtask

    task automatic wait_request();
        int unsigned n = 0;
        step();
        while (!cache_r_ready && n < 60) begin step(); n++; end
        chk("tmo_request", n < 60, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned base;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        cache_r_valid  = 1'b0;
        cache_r_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cache_r_ready, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_count", fq_count, 0);
        chk("rst_busy", fq_busy, 0);
        chk("rst_addr", cache_addr, 32'h8000_0000);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        rst = 1'b1;

        // reset then fetch, 1-cycle hit, decode stalled
        lat = 0; rdy_val = 0;
        n = 0;
        while (q.size() < 2 && n < 60) begin step(); n++; end
        chk("tmo_fetch", n < 60, 1);
        step();
        chk("first_inst", inst, 32'h0000_0413);
        chk("first_pc", inst_pc, 32'h8000_0000);

        // fill to full, then a single pop allows exactly one request
        n = 0;
        while (q.size() < DEPTH && n < 60) begin step(); n++; end
        chk("tmo_fill", n < 60, 1);
        repeat (6) step();
        chk("full_count", fq_count, DEPTH);
        base = req_cnt;
        rdy_val = 1; step(); rdy_val = 0;
        repeat (8) step();
        chk("one_request", req_cnt - base, 1);
        chk("refull_count", fq_count, DEPTH);

        // redirect while a request is outstanding without response
        lat = 3; rdy_val = 1;
        fire_redirect(2, 32'h8000_1000);
        n = 0;
        while (drop_pending && n < 60) begin step(); n++; end
        chk("tmo_drop", n < 60, 1);
        step();
        chk("drop_empty", fq_count, 0);
        wait_request();
        chk("drop_next_addr", cache_addr, 32'h8000_1000);

        // redirect coincident with response and pop
        lat = 0; rdy_val = 0;
        n = 0;
        while (q.size() < 1 && n < 60) begin step(); n++; end
        chk("tmo_prefill", n < 60, 1);
        force_rdy = 1;
        fire_redirect(1, 32'h8000_2000);
        force_rdy = 0;
        step();
        chk("coinc_flush", inst_valid, 0);
        wait_request();
        chk("coinc_addr", cache_addr, 32'h8000_2000);

        // unaligned redirect selects the high word
        fire_redirect(0, 32'h8000_0006);
        n = 0;
        while (q.size() < 1 && n < 60) begin step(); n++; end
        chk("tmo_unaligned", n < 60, 1);
        step();
        chk("unal_pc", inst_pc, 32'h8000_0004);
        chk("unal_inst", inst, 32'h0000_0297);

        // aligned line start with an empty queue
        fire_redirect(0, 32'h8000_0008);
        n = 0;
        while (q.size() == 0 && n < 60) begin step(); n++; end
        chk("tmo_pair", n < 60, 1);
        step();
`ifdef IFU_FQ_PAIR_EN
        chk("pair_count", fq_count, 2);
        chk("pair_head_pc", inst_pc, 32'h8000_0008);
        wait_request();
        chk("pair_next_addr", cache_addr, 32'h8000_0010);
`else
        chk("single_count", fq_count, 1);
        chk("single_head_pc", inst_pc, 32'h8000_0008);
        wait_request();
        chk("single_next_addr", cache_addr, 32'h8000_0008);
`endif

        // random traffic: random pops, latencies and redirects
        rdy_rand = 1;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(0, 3);
            if (!want_redir && $urandom_range(0, 24) == 0) begin
                want_redir = 1;
                redir_mode = 0;
                want_pc    = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            end
            step();
        end
        want_redir = 0;
        rdy_rand   = 0;

        // asynchronous reset in the middle of a request
        lat = 3;
        wait_request();
        #1 rst = 1'b0;
        #1;
        chk("midrst_ready", cache_r_ready, 0);
        chk("midrst_busy", fq_busy, 0);
        chk("midrst_count", fq_count, 0);
        chk("midrst_valid", inst_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
